// File: rtl/mem_arbiter_pkg.sv
// Shared types and bus widths for the mem_arbiter block.
package mem_arbiter_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Round-robin picker: first set request bit at or after ptr_i, wrapping.
// Purely combinational; idx_o is 0 when no request is set.
module rr_picker #(
   parameter int unsigned NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
   output logic                       any_o,
   output logic [$clog2(NUM_REQ)-1:0] idx_o
);

   localparam int unsigned IW = $clog2(NUM_REQ);

   int unsigned k;

   // Scan from the pointer upward; first hit wins
   always_comb begin
      any_o = 1'b0;
      idx_o = '0;
      k     = 0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         k = 32'(ptr_i) + off;
         if (k >= NUM_REQ) begin
            k = k - NUM_REQ;
         end
         if (!any_o && req_i[k[IW-1:0]]) begin
            any_o = 1'b1;
            idx_o = k[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one native memory bus between NUM_REQ
// requesters; one transfer in flight, grant held until mem_ready.
// Optional transfer timeout enabled by defining MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 2,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ-1:0]          req_instr,
   input  logic [ADDR_W*NUM_REQ-1:0]   req_addr,
   input  logic [DATA_W*NUM_REQ-1:0]   req_wdata,
   input  logic [STRB_W*NUM_REQ-1:0]   req_wstrb,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic [NUM_REQ-1:0]          req_error,
   output logic [DATA_W-1:0]           req_rdata,
   output logic                        mem_valid,
   output logic                        mem_instr,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_wdata,
   output logic [STRB_W-1:0]           mem_wstrb,
   input  logic                        mem_ready,
   input  logic [DATA_W-1:0]           mem_rdata,
   output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

   localparam int unsigned GW = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
      $error("mem_arbiter: unsupported parameter set");
   end

   state_e          state_q, state_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
   logic            pick_any;
   logic [GW-1:0]   pick_idx;
   logic            abort;

   rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .req_i (req_valid),
      .ptr_i (rr_ptr_q),
      .any_o (pick_any),
      .idx_o (pick_idx)
   );

`ifdef MEM_ARBITER_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Abort when the wait counter has reached the limit; a late mem_ready wins
   assign abort = (state_q == BUSY) && !mem_ready && (cnt_q == CW'(TIMEOUT_CYCLES));

   // Wait counter: held at zero outside BUSY, counts stalled BUSY cycles
   always_comb begin
      cnt_d = cnt_q;
      if (state_q != BUSY) begin
         cnt_d = '0;
      end else if (!mem_ready && !abort) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Wait counter register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign abort = 1'b0;
`endif

   // Next-state, memory-side mux and requester handshake
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      rr_ptr_d  = rr_ptr_q;
      mem_valid = 1'b0;
      mem_instr = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = '0;
      req_ready = '0;
      req_error = '0;
      req_rdata = '0;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               grant_d = pick_idx;
               state_d = BUSY;
            end
         end
         BUSY: begin
            mem_valid = !abort;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
               if (grant_q == GW'(i)) begin
                  mem_instr = req_instr[i];
                  mem_addr  = req_addr[i*ADDR_W +: ADDR_W];
                  mem_wdata = req_wdata[i*DATA_W +: DATA_W];
                  mem_wstrb = req_wstrb[i*STRB_W +: STRB_W];
               end
            end
            if (mem_ready || abort) begin
               req_ready[grant_q] = 1'b1;
               if (abort) begin
                  req_error[grant_q] = 1'b1;
               end else begin
                  req_rdata = mem_rdata;
               end
               rr_ptr_d = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, grant and round-robin pointer registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign grant_id = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter and its round-robin picker.
// Follows MEM_ARBITER_TIMEOUT_EN to choose the timeout or hold sequence.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   // Two-requester arbiter
   logic [1:0]  a_valid, a_instr, a_ready, a_error;
   logic [63:0] a_addr, a_wdata;
   logic [7:0]  a_wstrb;
   logic [31:0] a_rdata, a_maddr, a_mwdata, a_mrdata;
   logic        a_mvalid, a_minstr, a_mready;
   logic [3:0]  a_mwstrb;
   logic [0:0]  a_gid;

   // Three-requester arbiter for wrap checks
   logic [2:0]  b_valid, b_instr, b_ready, b_error;
   logic [95:0] b_addr, b_wdata;
   logic [11:0] b_wstrb;
   logic [31:0] b_rdata, b_maddr, b_mwdata, b_mrdata;
   logic        b_mvalid, b_minstr, b_mready;
   logic [3:0]  b_mwstrb;
   logic [1:0]  b_gid;

   // Stand-alone picker
   logic [2:0] p_req;
   logic [1:0] p_ptr, p_idx;
   logic       p_any;

   mem_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(4)) u_dut_a (
      .clk(clk), .reset(reset),
      .req_valid(a_valid), .req_instr(a_instr), .req_addr(a_addr),
      .req_wdata(a_wdata), .req_wstrb(a_wstrb),
      .req_ready(a_ready), .req_error(a_error), .req_rdata(a_rdata),
      .mem_valid(a_mvalid), .mem_instr(a_minstr), .mem_addr(a_maddr),
      .mem_wdata(a_mwdata), .mem_wstrb(a_mwstrb),
      .mem_ready(a_mready), .mem_rdata(a_mrdata), .grant_id(a_gid)
   );

   mem_arbiter #(.NUM_REQ(3), .TIMEOUT_CYCLES(255)) u_dut_b (
      .clk(clk), .reset(reset),
      .req_valid(b_valid), .req_instr(b_instr), .req_addr(b_addr),
      .req_wdata(b_wdata), .req_wstrb(b_wstrb),
      .req_ready(b_ready), .req_error(b_error), .req_rdata(b_rdata),
      .mem_valid(b_mvalid), .mem_instr(b_minstr), .mem_addr(b_maddr),
      .mem_wdata(b_mwdata), .mem_wstrb(b_mwstrb),
      .mem_ready(b_mready), .mem_rdata(b_mrdata), .grant_id(b_gid)
   );

   rr_picker #(.NUM_REQ(3)) u_pick (
      .req_i(p_req), .ptr_i(p_ptr), .any_o(p_any), .idx_o(p_idx)
   );

   typedef struct {
      logic [2:0] req;
      logic [1:0] ptr;
      logic       any;
      logic [1:0] idx;
   } pvec_t;

   pvec_t tbl [10];

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int unsigned g;
      logic [1:0]  exp_rdy;

      reset = 1'b0;
      a_valid = '0; a_instr = '0; a_addr = '0; a_wdata = '0; a_wstrb = '0;
      a_mready = 1'b0; a_mrdata = '0;
      b_valid = '0; b_instr = '0; b_addr = '0; b_wdata = '0; b_wstrb = '0;
      b_mready = 1'b0; b_mrdata = '0;
      p_req = '0; p_ptr = '0;

      // Picker vectors: {req, ptr} -> {any, idx}
      tbl[0] = '{3'b010, 2'd2, 1'b1, 2'd1};
      tbl[1] = '{3'b000, 2'd0, 1'b0, 2'd0};
      tbl[2] = '{3'b111, 2'd0, 1'b1, 2'd0};
      tbl[3] = '{3'b111, 2'd1, 1'b1, 2'd1};
      tbl[4] = '{3'b111, 2'd2, 1'b1, 2'd2};
      tbl[5] = '{3'b101, 2'd1, 1'b1, 2'd2};
      tbl[6] = '{3'b011, 2'd2, 1'b1, 2'd0};
      tbl[7] = '{3'b100, 2'd0, 1'b1, 2'd2};
      tbl[8] = '{3'b001, 2'd2, 1'b1, 2'd0};
      tbl[9] = '{3'b110, 2'd0, 1'b1, 2'd1};
      for (int i = 0; i < 10; i++) begin
         p_req = tbl[i].req;
         p_ptr = tbl[i].ptr;
         #1;
         chk("pick_any", 32'(p_any), 32'(tbl[i].any));
         chk("pick_idx", 32'(p_idx), 32'(tbl[i].idx));
      end

      // Reset state
      chk("rst_mvalid", 32'(a_mvalid), 0);
      chk("rst_ready", 32'(a_ready), 0);
      chk("rst_error", 32'(a_error), 0);
      chk("rst_gid", 32'(a_gid), 0);
      next();
      reset = 1'b1;

      // Contention, zero-wait memory: req0, req1, req0, req1, req0
      next();
      a_valid = 2'b11;
      a_addr = {32'h0000_2000, 32'h0000_1000};
      a_mready = 1'b1;
      a_mrdata = 32'hA5A5_0000;
      @(negedge clk);
      chk("cont_idle_ready", 32'(a_ready), 0);
      chk("cont_idle_mvalid", 32'(a_mvalid), 0);
      g = 0;
      for (int i = 1; i <= 9; i++) begin
         next();
         @(negedge clk);
         if (i % 2 == 1) begin
            g = ((i - 1) / 2) % 2;
            exp_rdy = (g == 1) ? 2'b10 : 2'b01;
            chk("cont_ready", 32'(a_ready), 32'(exp_rdy));
            chk("cont_mvalid", 32'(a_mvalid), 1);
            chk("cont_maddr", a_maddr, (g == 1) ? 32'h2000 : 32'h1000);
            chk("cont_rdata", a_rdata, 32'hA5A5_0000);
         end else begin
            chk("cont_ready", 32'(a_ready), 0);
            chk("cont_mvalid", 32'(a_mvalid), 0);
            chk("cont_maddr", a_maddr, 0);
            chk("cont_rdata", a_rdata, 0);
         end
         chk("cont_gid", 32'(a_gid), g);
         if (i == 7) a_valid[1] = 1'b0;
         if (i == 9) a_valid = 2'b00;
      end

      // Single instruction read with two wait states
      next();
      a_mready = 1'b0;
      a_valid = 2'b01;
      a_instr = 2'b01;
      a_addr[31:0] = 32'h0000_0100;
      a_wstrb = '0;
      a_mrdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("rd_idle_mvalid", 32'(a_mvalid), 0);
      next();
      @(negedge clk);
      chk("rd_mvalid", 32'(a_mvalid), 1);
      chk("rd_maddr", a_maddr, 32'h100);
      chk("rd_minstr", 32'(a_minstr), 1);
      chk("rd_mwstrb", 32'(a_mwstrb), 0);
      chk("rd_wait1_ready", 32'(a_ready), 0);
      chk("rd_gid", 32'(a_gid), 0);
      next();
      @(negedge clk);
      chk("rd_wait2_ready", 32'(a_ready), 0);
      chk("rd_wait2_mvalid", 32'(a_mvalid), 1);
      next();
      a_mready = 1'b1;
      @(negedge clk);
      chk("rd_ready", 32'(a_ready), 32'(2'b01));
      chk("rd_rdata", a_rdata, 32'hDEAD_BEEF);
      next();
      a_valid = 2'b00;
      a_mready = 1'b0;
      a_instr = 2'b00;
      @(negedge clk);
      chk("rd_done_mvalid", 32'(a_mvalid), 0);
      chk("rd_done_ready", 32'(a_ready), 0);
      chk("rd_done_rdata", a_rdata, 0);

      // Write forwarding from requester 1
      next();
      a_valid = 2'b10;
      a_addr = {32'h0000_0200, 32'h0000_0400};
      a_wdata = {32'h1234_5678, 32'hFFFF_0000};
      a_wstrb = {4'b0011, 4'b1111};
      a_instr = 2'b01;
      a_mrdata = '0;
      @(negedge clk);
      chk("wr_idle_maddr", a_maddr, 0);
      chk("wr_idle_mwstrb", 32'(a_mwstrb), 0);
      chk("wr_idle_mwdata", a_mwdata, 0);
      next();
      @(negedge clk);
      chk("wr_mvalid", 32'(a_mvalid), 1);
      chk("wr_maddr", a_maddr, 32'h200);
      chk("wr_mwdata", a_mwdata, 32'h1234_5678);
      chk("wr_mwstrb", 32'(a_mwstrb), 32'(4'b0011));
      chk("wr_minstr", 32'(a_minstr), 0);
      chk("wr_gid", 32'(a_gid), 1);
      chk("wr_wait_ready", 32'(a_ready), 0);
      next();
      a_mready = 1'b1;
      @(negedge clk);
      chk("wr_ready", 32'(a_ready), 32'(2'b10));
      next();
      a_valid = 2'b00;
      a_mready = 1'b0;
      a_instr = 2'b00;

      // Reset mid-transfer; pointer returns to requester 0
      next();
      a_valid = 2'b01;
      a_addr[31:0] = 32'h0000_0300;
      a_mready = 1'b1;
      next();
      @(negedge clk);
      chk("rs_pre_ready", 32'(a_ready), 32'(2'b01));
      next();
      a_valid = 2'b10;
      a_mready = 1'b0;
      next();
      @(negedge clk);
      chk("rs_busy_gid", 32'(a_gid), 1);
      chk("rs_busy_mvalid", 32'(a_mvalid), 1);
      #2;
      reset = 1'b0;
      #1;
      chk("rs_async_mvalid", 32'(a_mvalid), 0);
      chk("rs_async_gid", 32'(a_gid), 0);
      chk("rs_async_ready", 32'(a_ready), 0);
      a_valid = 2'b11;
      next();
      reset = 1'b1;
      @(negedge clk);
      chk("rs_rel_mvalid", 32'(a_mvalid), 0);
      next();
      @(negedge clk);
      chk("rs_first_gid", 32'(a_gid), 0);
      chk("rs_first_maddr", a_maddr, 32'h300);
      a_mready = 1'b1;
      #1;
      chk("rs_first_ready", 32'(a_ready), 32'(2'b01));
      a_valid[0] = 1'b0;
      next();
      next();
      @(negedge clk);
      chk("rs_second_gid", 32'(a_gid), 1);
      chk("rs_second_ready", 32'(a_ready), 32'(2'b10));
      chk("rs_second_maddr", a_maddr, 32'h200);
      next();
      a_valid = 2'b00;
      a_mready = 1'b0;

`ifdef MEM_ARBITER_TIMEOUT_EN
      // Timeout abort on the fifth stalled BUSY cycle
      next();
      a_valid = 2'b01;
      a_mrdata = 32'hCAFE_F00D;
      for (int k = 1; k <= 5; k++) begin
         next();
         @(negedge clk);
         if (k < 5) begin
            chk("to_mvalid", 32'(a_mvalid), 1);
            chk("to_ready", 32'(a_ready), 0);
            chk("to_error", 32'(a_error), 0);
         end else begin
            chk("to_abort_mvalid", 32'(a_mvalid), 0);
            chk("to_abort_ready", 32'(a_ready), 32'(2'b01));
            chk("to_abort_error", 32'(a_error), 32'(2'b01));
            chk("to_abort_rdata", a_rdata, 0);
         end
      end
      next();
      a_valid = 2'b00;
      @(negedge clk);
      chk("to_idle_mvalid", 32'(a_mvalid), 0);
      chk("to_idle_error", 32'(a_error), 0);
      // mem_ready in the timeout cycle completes normally
      next();
      a_valid = 2'b01;
      for (int k = 1; k <= 5; k++) begin
         next();
         if (k == 5) a_mready = 1'b1;
         @(negedge clk);
         if (k < 5) begin
            chk("toc_ready", 32'(a_ready), 0);
         end else begin
            chk("toc_ready", 32'(a_ready), 32'(2'b01));
            chk("toc_error", 32'(a_error), 0);
            chk("toc_rdata", a_rdata, 32'hCAFE_F00D);
            chk("toc_mvalid", 32'(a_mvalid), 1);
         end
      end
      next();
      a_valid = 2'b00;
      a_mready = 1'b0;
`else
      // Without the timeout, BUSY holds indefinitely
      next();
      a_valid = 2'b01;
      a_mrdata = 32'hCAFE_F00D;
      for (int k = 1; k <= 100; k++) begin
         next();
         @(negedge clk);
         chk("hold_mvalid", 32'(a_mvalid), 1);
      end
      chk("hold_error", 32'(a_error), 0);
      a_mready = 1'b1;
      #1;
      chk("hold_ready", 32'(a_ready), 32'(2'b01));
      chk("hold_done_error", 32'(a_error), 0);
      next();
      a_valid = 2'b00;
      a_mready = 1'b0;
`endif

      // Three requesters: wrap from pointer 2 back to requester 1
      next();
      b_valid = 3'b010;
      b_addr = {32'h0000_B002, 32'h0000_B001, 32'h0000_B000};
      b_mready = 1'b1;
      b_mrdata = 32'h0BAD_F00D;
      next();
      @(negedge clk);
      chk("wrap_first_gid", 32'(b_gid), 1);
      chk("wrap_first_ready", 32'(b_ready), 32'(3'b010));
      next();
      @(negedge clk);
      chk("wrap_idle_ready", 32'(b_ready), 0);
      next();
      @(negedge clk);
      chk("wrap_gid", 32'(b_gid), 1);
      chk("wrap_ready", 32'(b_ready), 32'(3'b010));
      chk("wrap_maddr", b_maddr, 32'hB001);
      b_valid = 3'b111;
      next();
      next();
      @(negedge clk);
      chk("wrap_ptr2_gid", 32'(b_gid), 2);
      chk("wrap_ptr2_ready", 32'(b_ready), 32'(3'b100));
      chk("wrap_ptr2_maddr", b_maddr, 32'hB002);
      next();
      next();
      @(negedge clk);
      chk("wrap_ptr0_gid", 32'(b_gid), 0);
      chk("wrap_ptr0_ready", 32'(b_ready), 32'(3'b001));
      b_valid = 3'b000;
      b_mready = 1'b0;
      next();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
